// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM encoding, requester ids and default widths for mem_arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundle of requester ports 0/1 (req/we/addr/wdata/gnt/rvalid/rdata, stall0) and memory data port (mem_we/addr/wdata/rdata)
interface mem_arbiter_if import mem_arb_pkg::*; #(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              req0, we0, gnt0, rvalid0, stall0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0, rdata0;
  logic              req1, we1, gnt1, rvalid1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1, rdata1;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    output gnt0, rvalid0, rdata0, stall0, gnt1, rvalid1, rdata1, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, mem_rdata,
    input  gnt0, rvalid0, rdata0, stall0, gnt1, rvalid1, rdata1, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker; ports clk, rst_n, req[1:0], advance (grant taken this cycle), winner
module rr_arb2 import mem_arb_pkg::*; (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       winner
);
  logic ptr_q, ptr_d;
  always_comb begin
    winner = &req ? ptr_q : req[1];
    ptr_d  = advance ? ~winner : ptr_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr_q <= PORT_CPU;
    else ptr_q <= ptr_d;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory data port by CPU (port 0) and loader (port 1); ports clk, rst_n, bus (mem_arbiter_if.slave)
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int READ_LAT = 1
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);
  state_t            state_q, state_d;
  logic              win_q, win_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              any_req, pick, iss, resp;
  assign any_req = bus.req0 | bus.req1;
  assign iss     = state_q == ISSUE;
  assign resp    = state_q == RESP;
  rr_arb2 u_rr (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({bus.req1, bus.req0}),
    .advance (state_q == IDLE && any_req),
    .winner  (pick)
  );
  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: if (any_req) begin
        state_d = ISSUE;
        win_d   = pick;
        we_d    = pick ? bus.we1 : bus.we0;
        addr_d  = pick ? bus.addr1 : bus.addr0;
        wdata_d = pick ? bus.wdata1 : bus.wdata0;
      end
      ISSUE: begin
        cnt_d   = 2'(READ_LAT - 1);
        state_d = we_q ? IDLE : (READ_LAT > 1 ? WAIT : RESP);
      end
      WAIT: begin
        cnt_d   = cnt_q - 2'd1;
        state_d = cnt_q == 2'd1 ? RESP : WAIT;
      end
      RESP: begin
        state_d  = IDLE;
        rdata0_d = win_q == PORT_CPU ? bus.mem_rdata : rdata0_q;
        rdata1_d = win_q == PORT_DBG ? bus.mem_rdata : rdata1_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      win_q    <= PORT_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  assign bus.gnt0      = iss && win_q == PORT_CPU;
  assign bus.gnt1      = iss && win_q == PORT_DBG;
  assign bus.rvalid0   = resp && win_q == PORT_CPU;
  assign bus.rvalid1   = resp && win_q == PORT_DBG;
  assign bus.rdata0    = bus.rvalid0 ? bus.mem_rdata : rdata0_q;
  assign bus.rdata1    = bus.rvalid1 ? bus.mem_rdata : rdata1_q;
  assign bus.stall0    = rst_n & bus.req0 & ~((bus.gnt0 & we_q) | bus.rvalid0);
  assign bus.mem_we    = iss & we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter with a behavioural memory and arbitration model
module tb_mem_arbiter;
  import mem_arb_pkg::*;
  localparam int RL = 3;
  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [31:0] wdata;
    int          start;
    int          drop;
  } txn_t;
  typedef struct {
    logic [31:0] data;
    int          cyc;
  } rd_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cyc = 0;
  int vectors = 0;
  int miscompares = 0;
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus ();
  mem_arbiter #(.ADDR_W(16), .DATA_W(32), .READ_LAT(RL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic [31:0] mem [256] = '{default: '0};
  logic [15:0] apipe [RL];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
    apipe[0] <= bus.mem_addr;
    for (int i = 1; i < RL; i++) apipe[i] <= apipe[i-1];
  end
  assign bus.mem_rdata = mem[apipe[RL-1][9:2]];
  logic        req_v [2];
  logic        we_v [2];
  logic [15:0] addr_v [2];
  logic [31:0] wdata_v [2];
  assign bus.req0   = req_v[0];
  assign bus.we0    = we_v[0];
  assign bus.addr0  = addr_v[0];
  assign bus.wdata0 = wdata_v[0];
  assign bus.req1   = req_v[1];
  assign bus.we1    = we_v[1];
  assign bus.addr1  = addr_v[1];
  assign bus.wdata1 = wdata_v[1];
  txn_t        stim_q [2][$];
  txn_t        exp_q [2][$];
  rd_t         rd_q [2][$];
  logic [31:0] model_mem [256] = '{default: '0};
  logic [31:0] last_rd [2];
  logic        pref;
  int          free_at;
  logic        prev_rst;
  logic        act [2];
  int          waited [2];
  int          cur_drop [2];
  logic        gs [2];
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, want);
    end
  endtask
  task automatic push(input int p, input logic w, input logic [15:0] a, input logic [31:0] d, input int drop);
    txn_t t;
    t.we = w;
    t.addr = a;
    t.wdata = d;
    t.start = 0;
    t.drop = drop;
    stim_q[p].push_back(t);
  endtask
  function automatic int pending();
    return stim_q[0].size() + stim_q[1].size() + exp_q[0].size() + exp_q[1].size()
         + rd_q[0].size() + rd_q[1].size() + int'(act[0]) + int'(act[1]);
  endfunction
  task automatic wait_quiet();
    int n;
    n = 0;
    while (pending() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("quiet_timeout", 64'(n >= 500), 64'(0));
    repeat (2) @(negedge clk);
  endtask
  task automatic wait_gnt0();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.gnt0 && n < 40);
    chk("gnt0_wait_timeout", 64'(!bus.gnt0), 64'(0));
  endtask
  initial begin : driver
    txn_t t;
    for (int p = 0; p < 2; p++) begin
      req_v[p] = 1'b0;
      we_v[p] = 1'b0;
      addr_v[p] = '0;
      wdata_v[p] = '0;
      act[p] = 1'b0;
      waited[p] = 0;
      cur_drop[p] = 0;
    end
    forever begin
      @(negedge clk);
      gs[0] = bus.gnt0;
      gs[1] = bus.gnt1;
      @(posedge clk);
      #1;
      for (int p = 0; p < 2; p++) begin
        if (!rst_n) begin
          act[p] = 1'b0;
          req_v[p] = 1'b0;
        end else begin
          if (act[p]) begin
            if (gs[p]) act[p] = 1'b0;
            else begin
              waited[p]++;
              if (cur_drop[p] > 0 && waited[p] >= cur_drop[p]) begin
                act[p] = 1'b0;
                if (exp_q[p].size() > 0) void'(exp_q[p].pop_back());
              end else if (waited[p] > 60) begin
                chk("gnt_timeout", 64'(1), 64'(0));
                act[p] = 1'b0;
                if (exp_q[p].size() > 0) void'(exp_q[p].pop_back());
              end
            end
          end
          if (!act[p]) begin
            if (stim_q[p].size() > 0) begin
              t = stim_q[p].pop_front();
              t.start = cyc;
              exp_q[p].push_back(t);
              act[p] = 1'b1;
              waited[p] = 0;
              cur_drop[p] = t.drop;
              req_v[p] = 1'b1;
              we_v[p] = t.we;
              addr_v[p] = t.addr;
              wdata_v[p] = t.wdata;
            end else req_v[p] = 1'b0;
          end
        end
      end
    end
  end
  initial begin : monitor
    logic        g, rv, wr_done, rd_done;
    logic [31:0] rd;
    txn_t        t;
    rd_t         r;
    int          o;
    prev_rst = 1'b0;
    pref = PORT_CPU;
    free_at = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("reset_outs", 64'(|{bus.gnt0, bus.rvalid0, bus.rdata0, bus.stall0, bus.gnt1, bus.rvalid1,
                               bus.rdata1, bus.mem_we, bus.mem_addr, bus.mem_wdata}), 64'(0));
        for (int p = 0; p < 2; p++) begin
          exp_q[p].delete();
          rd_q[p].delete();
          last_rd[p] = '0;
        end
        pref = PORT_CPU;
        prev_rst = 1'b0;
      end else begin
        if (!prev_rst) begin
          free_at = cyc;
          prev_rst = 1'b1;
        end
        chk("gnt_excl", 64'(bus.gnt0 & bus.gnt1), 64'(0));
        chk("mem_we_gate", 64'(bus.mem_we & ~(bus.gnt0 | bus.gnt1)), 64'(0));
        wr_done = bus.gnt0 && exp_q[0].size() > 0 && exp_q[0][0].we;
        rd_done = rd_q[0].size() > 0 && rd_q[0][0].cyc == cyc;
        chk("stall0", 64'(bus.stall0), 64'(req_v[0] & ~(wr_done | rd_done)));
        for (int p = 0; p < 2; p++) begin
          g  = p == 1 ? bus.gnt1 : bus.gnt0;
          rv = p == 1 ? bus.rvalid1 : bus.rvalid0;
          rd = p == 1 ? bus.rdata1 : bus.rdata0;
          if (g) begin
            if (exp_q[p].size() == 0) chk("gnt_unexpected", 64'(1), 64'(0));
            else begin
              t = exp_q[p].pop_front();
              o = 1 - p;
              if (exp_q[o].size() > 0 && exp_q[o][0].start <= cyc - 1)
                chk("rr_winner", 64'(p), 64'(pref));
              pref = p == 0;
              chk("gnt_latency", 64'(cyc), 64'((t.start > free_at ? t.start : free_at) + 1));
              chk("mem_we", 64'(bus.mem_we), 64'(t.we));
              chk("mem_addr", 64'(bus.mem_addr), 64'(t.addr));
              if (t.we) begin
                chk("mem_wdata", 64'(bus.mem_wdata), 64'(t.wdata));
                model_mem[t.addr[9:2]] = t.wdata;
                free_at = cyc + 1;
              end else begin
                r.data = model_mem[t.addr[9:2]];
                r.cyc = cyc + RL;
                rd_q[p].push_back(r);
              end
            end
          end
          if (rv) begin
            if (rd_q[p].size() == 0) chk("rvalid_unexpected", 64'(1), 64'(0));
            else begin
              r = rd_q[p].pop_front();
              chk("rvalid_cycle", 64'(cyc), 64'(r.cyc));
              chk("rdata", 64'(rd), 64'(r.data));
              last_rd[p] = r.data;
              free_at = cyc + 1;
            end
          end else begin
            chk("rdata_hold", 64'(rd), 64'(last_rd[p]));
            if (rd_q[p].size() > 0 && rd_q[p][0].cyc < cyc) begin
              chk("rvalid_missing", 64'(0), 64'(1));
              void'(rd_q[p].pop_front());
            end
          end
        end
      end
    end
  end
  initial begin : main
    int n;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (5) @(negedge clk);
    push(0, 1'b1, 16'h0040, 32'hDEADBEEF, 0);
    wait_quiet();
    push(0, 1'b0, 16'h0040, 32'h0, 0);
    wait_quiet();
    push(0, 1'b0, 16'h0040, 32'h0, 0);
    push(1, 1'b0, 16'h0004, 32'h0, 0);
    wait_quiet();
    push(0, 1'b1, 16'h0008, 32'h01234567, 0);
    wait_quiet();
    push(0, 1'b0, 16'h0008, 32'h0, 0);
    push(1, 1'b0, 16'h0040, 32'h0, 0);
    wait_quiet();
    push(0, 1'b0, 16'h0010, 32'h0, 0);
    wait_gnt0();
    push(1, 1'b1, 16'h0020, 32'h12345678, 1);
    wait_quiet();
    push(0, 1'b0, 16'h0020, 32'h0, 0);
    wait_quiet();
    push(1, 1'b1, 16'h0020, 32'hCAFEF00D, 0);
    push(0, 1'b0, 16'h0020, 32'h0, 0);
    wait_quiet();
    push(0, 1'b0, 16'h0040, 32'h0, 0);
    wait_gnt0();
    @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    push(1, 1'b1, 16'h0044, 32'h0BADCAFE, 0);
    wait_quiet();
    push(0, 1'b0, 16'h0044, 32'h0, 0);
    wait_quiet();
    for (int r = 0; r < 40; r++) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++)
        push(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom_range(0, 15) * 4), $urandom, 0);
      if ($urandom_range(0, 1) == 1) wait_quiet();
      else repeat ($urandom_range(0, 6)) @(negedge clk);
    end
    wait_quiet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
  initial begin : watchdog
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish before 2000000");
    $fatal(1);
  end
endmodule
